uart_core: RTL and testbench

//  Parametrised full-duplex UART: TX with input FIFO and valid/ready handshake, RX with
//  2-flop sync, glitch-rejecting start detect, parity and framing checks. Configurable

---
 rtl/uart_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_core.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: full-duplex UART. TX side is a small FIFO feeding a frame
// serialiser; RX side is a 2-flop synchroniser, glitch-checked start detect
// and mid-bit sampling deframer with parity/framing flags.
// Optional feature macro: UART_LOOPBACK_EN (adds 'loopback' input; when 1 the
// RX synchroniser is fed from rs232_tx instead of rs232_rx).
module uart_core #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 rs232_tx,
  input  logic                 rs232_rx,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [TX_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 tx_ready_q;
  logic                 push, pop, fifo_ne;
  logic [DATA_BITS-1:0] head;

  assign fifo_ne = (cnt_q != '0);
  assign push    = tx_valid & tx_ready_q;
  assign head    = mem_q[rd_ptr_q];
  assign cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  // FIFO storage; contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // FIFO pointers, occupancy and registered ready (= not full next cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q      <= cnt_d;
      tx_ready_q <= (cnt_d != (AW+1)'(TX_FIFO_DEPTH));
    end
  end

  // ---------------- TX framer ----------------
  state_e               tx_st_q;
  logic [CW-1:0]        tx_baud_q;
  logic [3:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q, tx_line_q, tx_done_q, tx_busy_q;
  logic                 tx_tick, tx_last_stop;

  assign tx_tick      = (tx_baud_q == BAUD_LAST);
  assign tx_last_stop = (tx_st_q == S_STOP) && tx_tick && (tx_bit_q == STOP_LAST);
  // Pop either from idle or at the very end of a frame for back-to-back sends
  assign pop          = fifo_ne && ((tx_st_q == S_IDLE) || tx_last_stop);

  // TX FSM; line output is registered, so it trails the state by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q   <= S_IDLE;
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_line_q <= 1'b1;
      tx_done_q <= 1'b0;
      tx_busy_q <= 1'b0;
    end else begin
      tx_done_q <= tx_last_stop;
      tx_busy_q <= (tx_st_q != S_IDLE) || fifo_ne;
      tx_baud_q <= (tx_st_q == S_IDLE || tx_tick) ? '0 : tx_baud_q + CW'(1);
      case (tx_st_q)
        S_IDLE: begin
          tx_line_q <= 1'b1;
          if (pop) begin
            tx_sh_q  <= head;
            tx_par_q <= (PARITY == 2) ? ~^head : ^head;
            tx_st_q  <= S_START;
          end
        end
        S_START: begin
          tx_line_q <= 1'b0;
          if (tx_tick) begin
            tx_st_q  <= S_DATA;
            tx_bit_q <= '0;
          end
        end
        S_DATA: begin
          tx_line_q <= tx_sh_q[0];
          if (tx_tick) begin
            tx_sh_q <= tx_sh_q >> 1;
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_q <= '0;
              tx_st_q  <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end
        end
        S_PAR: begin
          tx_line_q <= tx_par_q;
          if (tx_tick) tx_st_q <= S_STOP;
        end
        S_STOP: begin
          tx_line_q <= 1'b1;
          if (tx_tick) begin
            if (tx_bit_q == STOP_LAST) begin
              tx_bit_q <= '0;
              if (pop) begin
                tx_sh_q  <= head;
                tx_par_q <= (PARITY == 2) ? ~^head : ^head;
                tx_st_q  <= S_START;
              end else begin
                tx_st_q  <= S_IDLE;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end
        end
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic rx_in;
`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_line_q : rs232_rx;
`else
  assign rx_in = rs232_rx;
`endif

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  state_e               rx_st_q;
  logic [CW-1:0]        rx_baud_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q, rx_data_q;
  logic                 rx_pbit_q, rx_valid_q, rx_perr_q, rx_ferr_q;
  logic                 rx_tick;

  assign rx_tick = (rx_baud_q == BAUD_LAST);

  // Two-flop synchroniser plus one delayed copy for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX FSM: half-bit start recheck, then one sample per bit at mid-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q    <= S_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pbit_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_baud_q  <= (rx_st_q == S_IDLE || rx_tick) ? '0 : rx_baud_q + CW'(1);
      case (rx_st_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_sync_q) rx_st_q <= S_START;
        end
        S_START: begin
          if (rx_baud_q == HALF_LAST) begin
            rx_baud_q <= '0;
            if (rx_sync_q) begin
              rx_st_q <= S_IDLE;
            end else begin
              rx_st_q  <= S_DATA;
              rx_bit_q <= '0;
            end
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_sh_q <= {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == DATA_LAST) begin
              rx_bit_q <= '0;
              rx_st_q  <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (rx_tick) begin
            rx_pbit_q <= rx_sync_q;
            rx_st_q   <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_tick) begin
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
            rx_ferr_q  <= ~rx_sync_q;
            rx_perr_q  <= (PARITY != 0) &&
                          (rx_pbit_q != ((PARITY == 2) ? ~^rx_sh_q : ^rx_sh_q));
            rx_st_q    <= S_IDLE;
          end
        end
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready      = tx_ready_q;
  assign tx_busy       = tx_busy_q;
  assign tx_done       = tx_done_q;
  assign rs232_tx      = tx_line_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: 8N1 instance (optionally looped tx->rx) plus an 8E1
// instance for parity. Line monitor decodes rs232_tx by mid-bit sampling.
module tb_uart_core;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, tx_data_p, rx_data, rx_data_p;
  logic       tx_valid, tx_ready, tx_busy, tx_done, tx_o, rx_pin;
  logic       rx_valid, perr, ferr;
  logic       tx_valid_p, tx_ready_p, tx_busy_p, tx_done_p, tx_o_p;
  logic       rx_valid_p, perr_p, ferr_p;
  logic       rx_drv, rx_drv_p, lb_wire;
`ifdef UART_LOOPBACK_EN
  logic       loopback;
`endif

  always #5 clk = ~clk;
  assign rx_pin = lb_wire ? tx_o : rx_drv;

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
              .TX_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
    .rs232_tx(tx_o), .rs232_rx(rx_pin),
`ifdef UART_LOOPBACK_EN
    .loopback(loopback),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(perr),
    .rx_frame_err(ferr));

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
              .TX_FIFO_DEPTH(4)) dut_p (
    .clk(clk), .rst(rst), .tx_data(tx_data_p), .tx_valid(tx_valid_p),
    .tx_ready(tx_ready_p), .tx_busy(tx_busy_p), .tx_done(tx_done_p),
    .rs232_tx(tx_o_p), .rs232_rx(rx_drv_p),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_parity_err(perr_p),
    .rx_frame_err(ferr_p));

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } rxv_t;
  rxv_t tbl [5];

  int         cmp_n = 0, err_n = 0, cyc = 0;
  int         busy_fall_t, t_acc;
  int         done_t [$];
  logic [8:0] mon_q [$];
  logic [9:0] rx_q [$], rxp_q [$];
  logic [7:0] exp_q [$];
  bit         busy_prev = 0, full_seen = 0, tx_low_seen = 0, mon_en = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled away from the active edge
  initial forever begin
    @(negedge clk);
    if (rx_valid === 1'b1)   rx_q.push_back({perr, ferr, rx_data});
    if (rx_valid_p === 1'b1) rxp_q.push_back({perr_p, ferr_p, rx_data_p});
    if (tx_done === 1'b1)    done_t.push_back(cyc);
    if (busy_prev && tx_busy === 1'b0) busy_fall_t = cyc;
    busy_prev = (tx_busy === 1'b1);
    if (tx_ready === 1'b0) full_seen = 1;
    if (tx_o === 1'b0) tx_low_seen = 1;
  end

  // Reference line decoder: falling edge, half a bit, then one bit period per sample
  initial begin
    logic [7:0] w;
    logic       sb;
    forever begin
      @(negedge tx_o);
      repeat (CPB/2) @(posedge clk);
      #1;
      if (tx_o === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1 w[i] = tx_o;
        end
        repeat (CPB) @(posedge clk);
        #1 sb = tx_o;
        if (mon_en) mon_q.push_back({sb, w});
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic int qsz(input int which);
    case (which)
      0: return mon_q.size();
      1: return rx_q.size();
      2: return rxp_q.size();
      default: return done_t.size();
    endcase
  endfunction

  function automatic logic [9:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 'x;
  endfunction
  function automatic logic [9:0] rxp_at(input int i);
    if (i < rxp_q.size()) return rxp_q[i];
    return 'x;
  endfunction
  function automatic logic [8:0] mon_at(input int i);
    if (i < mon_q.size()) return mon_q[i];
    return 'x;
  endfunction

  task automatic wait_sz(input int which, input int want, input int maxc, input string nm);
    int n = 0;
    while (qsz(which) < want && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, qsz(which), want);
  endtask

  task automatic clear_all();
    mon_q.delete(); rx_q.delete(); rxp_q.delete(); exp_q.delete(); done_t.delete();
  endtask

  task automatic push(input bit sel, input logic [7:0] w);
    int n = 0;
    @(negedge clk);
    if (sel) begin tx_data_p = w; tx_valid_p = 1'b1; end
    else     begin tx_data   = w; tx_valid   = 1'b1; end
    while (((sel ? tx_ready_p : tx_ready) !== 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      cmp_n++; err_n++;
      $display("FAIL push_timeout got=tx_ready_low exp=accept");
    end else begin
      @(posedge clk);
      if (!sel) exp_q.push_back(w);
    end
    #1;
    tx_valid   = 1'b0;
    tx_valid_p = 1'b0;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_drv_p = v; else rx_drv = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit hp,
                            input bit pb, input bit sb);
    @(negedge clk);
    drive(sel, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      repeat (CPB) @(negedge clk);
    end
    if (hp) begin
      drive(sel, pb);
      repeat (CPB) @(negedge clk);
    end
    drive(sel, sb);
    repeat (CPB) @(negedge clk);
    drive(sel, 1'b1);
  endtask

  initial begin
    tbl[0] = '{d: 8'h07, pb: 1'b0, sb: 1'b1, ed: 8'h07, ep: 1'b1, ef: 1'b0};
    tbl[1] = '{d: 8'h07, pb: 1'b1, sb: 1'b1, ed: 8'h07, ep: 1'b0, ef: 1'b0};
    tbl[2] = '{d: 8'hFF, pb: 1'b0, sb: 1'b1, ed: 8'hFF, ep: 1'b0, ef: 1'b0};
    tbl[3] = '{d: 8'h80, pb: 1'b1, sb: 1'b0, ed: 8'h80, ep: 1'b0, ef: 1'b1};
    tbl[4] = '{d: 8'h00, pb: 1'b1, sb: 1'b1, ed: 8'h00, ep: 1'b1, ef: 1'b0};

    rst = 1'b1; tx_valid = 1'b0; tx_valid_p = 1'b0; tx_data = '0; tx_data_p = '0;
    rx_drv = 1'b1; rx_drv_p = 1'b1; lb_wire = 1'b0; busy_fall_t = -1;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx_o, 1);       chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);  chk("rst_done", tx_done, 0);
    chk("rst_rxdata", rx_data, 0); chk("rst_rxvalid", rx_valid, 0);
    chk("rst_perr", perr, 0);     chk("rst_ferr", ferr, 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);

    // Loopback pair, latency and exact frame length
    lb_wire = 1'b1; clear_all();
    push(0, 8'hA5);
    t_acc = cyc;
    @(posedge clk); #1 chk("lat_n1", tx_o, 1);
    @(posedge clk); #1 chk("lat_n2", tx_o, 0);
    push(0, 8'h3C);
    wait_sz(1, 2, 600, "t1_rx_cnt");
    wait_sz(3, 2, 100, "t1_done_cnt");
    wait_sz(0, 2, 100, "t1_mon_cnt");
    for (int i = 0; i < 2; i++) begin
      chk("t1_rx", rx_at(i), {2'b00, exp_q[i]});
      chk("t1_line", mon_at(i), {1'b1, exp_q[i]});
    end
    chk("t1_len", done_t[0] - t_acc, 161);
    chk("t1_gap", done_t[1] - done_t[0], 160);

    // Six words into a depth-4 FIFO
    repeat (40) @(negedge clk);
    clear_all(); full_seen = 0; busy_fall_t = -1;
    for (int i = 0; i < 6; i++) push(0, 8'($urandom));
    wait_sz(0, 6, 1500, "t2_mon_cnt");
    wait_sz(3, 6, 100, "t2_done_cnt");
    wait_sz(1, 6, 100, "t2_rx_cnt");
    repeat (4) @(negedge clk);
    chk("t2_full_seen", full_seen, 1);
    for (int i = 0; i < 6; i++) begin
      chk("t2_line", mon_at(i), {1'b1, exp_q[i]});
      chk("t2_rx", rx_at(i), {2'b00, exp_q[i]});
    end
    chk("t2_busy_fall", busy_fall_t, done_t[5] + 1);

    // Random words with random gaps against the line decoder and loopback RX
    clear_all();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 250)) @(negedge clk);
      push(0, 8'($urandom));
    end
    wait_sz(0, 12, 2500, "rnd_mon_cnt");
    wait_sz(1, 12, 100, "rnd_rx_cnt");
    for (int i = 0; i < 12; i++) begin
      chk("rnd_line", mon_at(i), {1'b1, exp_q[i]});
      chk("rnd_rx", rx_at(i), {2'b00, exp_q[i]});
    end
    repeat (20) @(negedge clk);
    lb_wire = 1'b0;

    // Even-parity TX of 0x07: bit0=1, parity=1, stop=1
    push(1, 8'h07);
    repeat (26) @(posedge clk);  #1 chk("t3_bit0", tx_o_p, 1);
    repeat (128) @(posedge clk); #1 chk("t3_parity", tx_o_p, 1);
    repeat (16) @(posedge clk);  #1 chk("t3_stop", tx_o_p, 1);

    // Table-driven RX vectors on the parity instance
    clear_all();
    for (int i = 0; i < 5; i++) begin
      send_frame(1, tbl[i].d, 1'b1, tbl[i].pb, tbl[i].sb);
      repeat (2*CPB) @(negedge clk);
      wait_sz(2, i + 1, 200, "tbl_cnt");
      chk("tbl_rx", rxp_at(i), {tbl[i].ep, tbl[i].ef, tbl[i].ed});
    end

    // Framing error then clean frame
    clear_all();
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (2*CPB) @(negedge clk);
    send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1);
    wait_sz(1, 2, 200, "t4_cnt");
    chk("t4_ferr", rx_at(0), {2'b01, 8'h55});
    chk("t4_clean", rx_at(1), {2'b00, 8'hAA});

    // 4-cycle glitch is rejected, frame 20 cycles later is received
    clear_all();
    @(negedge clk) rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (15) @(negedge clk);
    chk("t5_glitch", rx_q.size(), 0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_sz(1, 1, 200, "t5_cnt");
    chk("t5_rx", rx_at(0), {2'b00, 8'h3C});

    // Asynchronous reset during data bit 3
    repeat (10) @(negedge clk);
    mon_en = 0;
    push(0, 8'h00);
    push(0, 8'h11);
    repeat (70) @(posedge clk);
    #1 chk("t6_pre", tx_o, 0);
    #1 rst = 1'b1;
    #1;
    chk("t6_tx", tx_o, 1);
    chk("t6_ready", tx_ready, 1);
    chk("t6_busy", tx_busy, 0);
    @(negedge clk) rst = 1'b0;
    tx_low_seen = 0; done_t.delete();
    repeat (400) @(negedge clk);
    chk("t6_no_frame", tx_low_seen, 0);
    chk("t6_no_done", done_t.size(), 0);
    chk("t6_busy_after", tx_busy, 0);
    mon_en = 1;

`ifdef UART_LOOPBACK_EN
    // Internal loopback with the pin held low
    loopback = 1'b1;
    repeat (4) @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    clear_all();
    push(0, 8'hA5);
    push(0, 8'h3C);
    wait_sz(1, 2, 600, "lb_cnt");
    wait_sz(3, 2, 100, "lb_done_cnt");
    chk("lb_rx0", rx_at(0), {2'b00, 8'hA5});
    chk("lb_rx1", rx_at(1), {2'b00, 8'h3C});
    chk("lb_gap", done_t[1] - done_t[0], 160);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    loopback = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
